// File: rtl/led_sequence_controller_pkg.sv
// Shared definitions for the LED sequence controller.
// Holds the mode and FSM state encodings, the code constants, and a helper
// that returns the first code shown for a given mode.
package led_sequence_controller_pkg;

  typedef enum logic [1:0] {
    MODE_FWD    = 2'b00,
    MODE_REV    = 2'b01,
    MODE_PING   = 2'b10,
    MODE_SINGLE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [2:0] CODE_OFF   = 3'd0;
  localparam logic [2:0] CODE_FIRST = 3'd1;
  localparam logic [2:0] CODE_LAST  = 3'd7;

  // Reverse starts from the top code; every other mode starts from the bottom.
  function automatic logic [2:0] first_code(input mode_e m);
    return (m == MODE_REV) ? CODE_LAST : CODE_FIRST;
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Dwell prescaler for the LED sequencer.
// Counts 0..DIV-1 while enabled; tick is high in the cycle the count sits at
// DIV-1 with enable asserted, and the counter wraps to 0 on that edge.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear to 0 (wins over enable)
//   en    : count enable; when low the count is frozen
//   tick  : end-of-dwell strobe
module led_step_prescaler #(
  parameter int unsigned DIV = 12_500_000,
  parameter int unsigned PW  = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequence_controller.sv
// LED sequence controller: steps a 3-bit code (A = MSB) through a forward,
// reverse, ping-pong or single-sweep pattern, holding each code DIV cycles,
// counting completed passes and pulsing done on normal completion.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start/stop/pause: level controls (stop > pause > tick)
//   mode, loops     : pattern and pass count, latched at start
//   A, B, C         : registered code to the LED decoder
//   busy, done      : run indication, one-cycle completion pulse
//   pass_cnt        : passes completed in the current run (saturates at 15)
module led_sequence_controller
  import led_sequence_controller_pkg::*;
#(
  parameter int unsigned DIV = 12_500_000,
  parameter int unsigned PW  = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [3:0] loops,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_cnt
);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [3:0] loops_q, loops_d;
  logic [3:0] pass_q, pass_d;
  logic [2:0] code_q, code_d;
  logic       dir_down_q, dir_down_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       presc_clr, presc_en, tick;
  logic       pass_done;
  logic [3:0] pass_next;

  led_step_prescaler #(
    .DIV (DIV),
    .PW  (PW)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    loops_d    = loops_q;
    pass_d     = pass_q;
    code_d     = code_q;
    dir_down_d = dir_down_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    presc_clr  = 1'b0;
    presc_en   = 1'b0;
    pass_done  = 1'b0;
    pass_next  = (pass_q == 4'hF) ? pass_q : pass_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        code_d    = CODE_OFF;
        busy_d    = 1'b0;
        presc_clr = 1'b1;
        if (start && !stop) begin
          mode_d     = mode_e'(mode);
          loops_d    = loops;
          pass_d     = '0;
          code_d     = first_code(mode_e'(mode));
          dir_down_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_RUN;
        end
      end

      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          state_d   = ST_IDLE;
          code_d    = CODE_OFF;
          busy_d    = 1'b0;
          presc_clr = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          // Leaving PAUSE counts in the same cycle, so the dwell is frozen
          // for exactly the cycles pause is sampled high.
          state_d  = ST_RUN;
          presc_en = 1'b1;
          if (tick) begin
            case (mode_q)
              MODE_FWD, MODE_SINGLE: begin
                if (code_q == CODE_LAST) pass_done = 1'b1;
                else                     code_d = code_q + 3'd1;
              end
              MODE_REV: begin
                if (code_q == CODE_FIRST) pass_done = 1'b1;
                else                      code_d = code_q - 3'd1;
              end
              MODE_PING: begin
                // Direction flips on landing at either end, so the ends
                // are shown once; the pass closes on the step down to 1.
                if (!dir_down_q) begin
                  code_d = code_q + 3'd1;
                  if (code_q == CODE_LAST - 3'd1) dir_down_d = 1'b1;
                end else begin
                  code_d = code_q - 3'd1;
                  if (code_q == CODE_FIRST + 3'd1) begin
                    dir_down_d = 1'b0;
                    pass_done  = 1'b1;
                  end
                end
              end
              default: ;
            endcase

            if (pass_done) begin
              pass_d = pass_next;
              if (mode_q == MODE_SINGLE || (loops_q != '0 && pass_next == loops_q)) begin
                state_d = ST_IDLE;
                code_d  = CODE_OFF;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else if (mode_q != MODE_PING) begin
                code_d = first_code(mode_q);
              end
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        code_d    = CODE_OFF;
        busy_d    = 1'b0;
        presc_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FWD;
      loops_q    <= '0;
      pass_q     <= '0;
      code_q     <= CODE_OFF;
      dir_down_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      loops_q    <= loops_d;
      pass_q     <= pass_d;
      code_q     <= code_d;
      dir_down_q <= dir_down_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign {A, B, C} = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;

endmodule

// File: tb/tb_led_sequence_controller.sv
module tb_led_sequence_controller;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = '0;
  logic [3:0] loops = '0;
  logic       A, B, C, busy, done;
  logic [3:0] pass_cnt;
  logic [2:0] code_w;

  int checks = 0;
  int errors = 0;
  int pat[$];

  typedef struct {
    logic [1:0] mode;
    logic [3:0] loops;
    int         cycles;
    int         first_code;
    int         last_code;
    int         sevens;
    int         passes;
  } vec_t;

  vec_t tbl[7];

  led_sequence_controller #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .loops    (loops),
    .A        (A),
    .B        (B),
    .C        (C),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  assign code_w = {A, B, C};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [1:0] m, input logic [3:0] l);
    mode  = m;
    loops = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One pass of each pattern, as a list of codes.
  task automatic fill_pattern(input int m);
    pat.delete();
    case (m)
      0: for (int c = 1; c <= 7; c++) pat.push_back(c);
      1: for (int c = 7; c >= 1; c--) pat.push_back(c);
      2: begin
        for (int c = 1; c <= 7; c++) pat.push_back(c);
        for (int c = 6; c >= 2; c--) pat.push_back(c);
      end
      default: for (int c = 1; c <= 7; c++) pat.push_back(c);
    endcase
  endtask

  // Random run: the model position advances one cycle per un-paused clock
  // through the expanded pattern; everything else is derived from it.
  task automatic random_run();
    int  m, l, passes, plen, total, pos, n;
    logic p;
    m = $urandom_range(0, 3);
    l = $urandom_range(1, 3);
    if (m == 3) l = $urandom_range(0, 15);
    fill_pattern(m);
    plen   = pat.size();
    passes = (m == 3) ? 1 : l;
    total  = passes * plen * DIV;
    begin_run(2'(m), 4'(l));
    pos = 0;
    chk("rnd_first_code", code_w, pat[0]);
    chk("rnd_first_busy", busy, 1);
    n = 0;
    while (pos < total && n < 4000) begin
      p     = ($urandom_range(0, 4) == 0);
      pause = p;
      start = 1'($urandom_range(0, 1));
      mode  = 2'($urandom);
      loops = 4'($urandom);
      step();
      n++;
      if (!p) pos++;
      if (pos < total) begin
        chk("rnd_code", code_w, pat[(pos / DIV) % plen]);
        chk("rnd_pass", pass_cnt, pos / (plen * DIV));
        chk("rnd_busy", busy, 1);
        chk("rnd_done_early", done, 0);
      end
    end
    pause = 1'b0;
    start = 1'b0;
    chk("rnd_done_pulse", done, 1);
    chk("rnd_end_code", code_w, 0);
    chk("rnd_end_busy", busy, 0);
    chk("rnd_end_pass", pass_cnt, passes);
    step();
    chk("rnd_done_one_cycle", done, 0);
  endtask

  initial begin
    int n, last, sevens, cnt3, j;

    tbl[0] = '{2'b00, 4'd1, 28, 1, 7, 4, 1};
    tbl[1] = '{2'b01, 4'd2, 56, 7, 1, 8, 2};
    tbl[2] = '{2'b10, 4'd1, 48, 1, 2, 4, 1};
    tbl[3] = '{2'b11, 4'd0, 28, 1, 7, 4, 1};
    tbl[4] = '{2'b11, 4'd9, 28, 1, 7, 4, 1};
    tbl[5] = '{2'b00, 4'd3, 84, 1, 7, 12, 3};
    tbl[6] = '{2'b10, 4'd2, 96, 1, 2, 8, 2};

    // Reset state
    #12;
    chk("reset_code", code_w, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_code", code_w, 0);

    // Table-driven complete runs
    for (int i = 0; i < 7; i++) begin
      begin_run(tbl[i].mode, tbl[i].loops);
      chk("tbl_first_code", code_w, tbl[i].first_code);
      chk("tbl_busy", busy, 1);
      n = 0;
      sevens = 0;
      last = code_w;
      while (!done && n < 1000) begin
        if (code_w == 7) sevens++;
        last = code_w;
        step();
        n++;
      end
      chk("tbl_done", done, 1);
      chk("tbl_cycles", n, tbl[i].cycles);
      chk("tbl_last_code", last, tbl[i].last_code);
      chk("tbl_sevens", sevens, tbl[i].sevens);
      chk("tbl_end_code", code_w, 0);
      chk("tbl_end_busy", busy, 0);
      chk("tbl_pass", pass_cnt, tbl[i].passes);
      step();
      chk("tbl_done_one_cycle", done, 0);
      chk("tbl_idle_busy", busy, 0);
      step();
    end

    // Pause for 10 cycles during code 3
    begin_run(2'b00, 4'd1);
    n = 0;
    while (code_w != 3 && n < 100) begin
      step();
      n++;
    end
    chk("pause_reach3", code_w, 3);
    cnt3 = 0;
    j = 0;
    while (code_w == 3 && j < 40) begin
      cnt3++;
      pause = (j >= 1 && j <= 10);
      step();
      if (pause) chk("pause_busy", busy, 1);
      j++;
    end
    pause = 1'b0;
    chk("pause_hold3", cnt3, 4 + 10);
    chk("pause_next_code", code_w, 4);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk("pause_done", done, 1);
    chk("pause_pass", pass_cnt, 1);
    step();

    // Stop at code 5 in the second pass, with start in the same cycle
    begin_run(2'b00, 4'd0);
    n = 0;
    while (!(code_w == 5 && pass_cnt == 1) && n < 200) begin
      step();
      n++;
    end
    chk("stop_reach5", code_w, 5);
    stop  = 1'b1;
    start = 1'b1;
    step();
    chk("stop_code", code_w, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_pass_hold", pass_cnt, 1);
    step();
    chk("stop_start_idle_busy", busy, 0);
    chk("stop_start_idle_code", code_w, 0);
    stop  = 1'b0;
    start = 1'b0;
    step();
    chk("stop_after_done", done, 0);
    chk("stop_after_code", code_w, 0);

    // pass_cnt saturation with loops=0
    begin_run(2'b00, 4'd0);
    repeat (16 * 7 * DIV + 2) step();
    chk("sat_pass", pass_cnt, 15);
    chk("sat_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_stop_busy", busy, 0);

    // Asynchronous reset mid-run
    begin_run(2'b00, 4'd0);
    repeat (35) step();
    chk("rst_pre_pass", pass_cnt, 1);
    chk("rst_pre_code", code_w, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_code", code_w, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_pass", pass_cnt, 0);
    chk("rst_async_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_stay_idle_code", code_w, 0);
    chk("rst_stay_idle_busy", busy, 0);

    // Randomized runs against the model
    for (int r = 0; r < 10; r++) begin
      random_run();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequence_controller.md
Name: led_sequence_controller

Overview:
Sequencer that drives the 3-bit LED code inputs (A, B, C; A = MSB) of the seven-LED one-hot decoder. Code 0 means all LEDs off; codes 1..7 light LED0..LED6. The block steps the code through a chosen pattern at a prescaled rate, counts completed passes and signals completion. It sits between the user controls (buttons or switches) and the decoder.

Parameters:
DIV, 12_500_000, clock cycles each code is held (dwell); must be >= 2; benches use DIV=4
PW, $clog2(DIV), prescaler counter width (derived)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level, sampled each cycle; begins a sequence from IDLE
stop  input  1  level; aborts from any state
pause  input  1  level; freezes the sequence while high in RUN
mode  input  2  00 forward, 01 reverse, 10 ping-pong, 11 single sweep
loops  input  4  passes before done; 0 = run forever (ignored in mode 11)
A  output  1  code bit 2 to decoder
B  output  1  code bit 1
C  output  1  code bit 0
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle pulse on normal completion
pass_cnt  output  4  passes completed in the current run

Behaviour:
- One clock domain; rst_n is asynchronous, active-low. Reset forces state IDLE, code=0, prescaler=0, pass_cnt=0, busy=0, done=0, direction=up, latched mode/loops=0.
- FSM states: IDLE, RUN, PAUSE.
- IDLE: code=0. If start=1 and stop=0, latch mode and loops, clear pass_cnt and prescaler, and load the first code. The first code is 7 for mode 01 and 1 for all other modes. Direction is set to up. Go to RUN. The first code appears the cycle after start is sampled.
- Mode and loops are sampled only at start. Changes during a run are ignored.
- RUN: the prescaler increments every cycle. When it reaches DIV-1 (tick), it clears and the code advances. Every code, including the first, is held exactly DIV cycles.
- Forward: the code steps 1→2→…→7. A tick while code=7 completes a pass.
- Reverse: the code steps 7→6→…→1. A tick while code=1 completes a pass.
- Ping-pong: 1→…→7→6→…→1→2…. Ends are shown once with no repeat. Direction flips when the tick lands on 7 (down) or on 1 (up). A pass completes on a tick at code=2 while direction is down, so the next code is 1. One pass is 12 dwells.
- Single sweep: 1..7 once. The tick at code=7 ends the run regardless of loops.
- On pass completion, pass_cnt increments and saturates at 15.
  - If loops≠0 and the new count equals loops, or mode=11: go to IDLE, code=0, done=1 for that cycle.
  - Otherwise the code wraps to the first code (forward/reverse) or continues (ping-pong).
- PAUSE: entered from RUN when pause=1. Code and prescaler are frozen. Return to RUN when pause=0. Pause has no effect in IDLE.
- stop=1 in any state: next cycle is IDLE with code=0, prescaler=0, and no done pulse. pass_cnt holds its value until the next start.
- Priority when signals coincide: stop > pause > tick. start while busy is ignored. start together with stop in IDLE is ignored.
- With loops=0, the run never ends on its own. pass_cnt saturates at 15.
- Reset mid-run returns everything immediately to reset values. No done pulse is produced.
- All outputs come from registers. No combinational path runs from inputs to outputs.

Decomposition:
- Shared package holds:
  - mode encodings MODE_FWD=2'b00, MODE_REV=2'b01, MODE_PING=2'b10, MODE_SINGLE=2'b11
  - state encodings
  - CODE_OFF=3'd0, CODE_FIRST=3'd1, CODE_LAST=3'd7
- One sub-module, led_step_prescaler: a DIV-cycle counter with clear and enable inputs and a tick output.
- The decoder itself is instantiated at top level, not inside this block.

Test Plan:
- Forward, DIV=4, loops=1, start pulsed at edge 0 → code 1..7, each for 4 cycles from edge 1. At edge 29, code=0 and done=1 for exactly one cycle. pass_cnt=1.
- Reverse, loops=2 → code 7..1, 7..1 (56 cycles). done occurs after the second pass. pass_cnt=2. busy falls with done.
- Ping-pong, loops=1 → sequence 1,2,3,4,5,6,7,6,5,4,3,2 then code=0 with done. No doubled 7. Total 48 cycles.
- Pause asserted for 10 cycles while code=3 → code holds 3 for 4+10 cycles total. Prescaler position is preserved across the pause.
- stop asserted at code=5 → next cycle code=0, busy=0, done stays 0. start asserted in the same cycle as stop is ignored.
- Mode 11 with loops=0 → a single 1..7 sweep, then done. Separately, rst_n pulsed low mid-run → outputs 0 asynchronously, and the FSM stays in IDLE until the next start.
